bar_history_ctrl: RTL and testbench

BAR_HISTORY_CTRL -- requirements
Module: bar_history_ctrl

---
 rtl/bar_pkg.sv | 21 ++
 rtl/bar_history_ctrl_if.sv | 11 +
 rtl/bar_ring_buf.sv | 30 +++
 rtl/bar_history_ctrl.sv | 147 ++++++++++++++
 tb/tb_bar_history_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bar_pkg.sv
// Shared constants and FSM encoding for the bar-graph history controller.
package bar_pkg;

    localparam int unsigned DEF_NUM_BARS          = 30;
    localparam int unsigned DEF_BAR_W             = 21;
    localparam int unsigned DEF_HEIGHT_SCALE      = 25;
    localparam int unsigned DEF_FRAMES_PER_UPDATE = 4;
    localparam int unsigned DEF_VACTIVE           = 480;

    // Zone bands are measured upward from the bottom visible line.
    localparam int unsigned ZONE0_OFS = 77;
    localparam int unsigned ZONE1_OFS = 177;

    localparam logic [4:0] IDX_NONE = 5'd31;

    typedef enum logic {
        IDLE,
        COMMIT
    } state_t;

endpackage

// File: rtl/bar_history_ctrl_if.sv
// Level-sample valid/ready handshake into the history controller.
interface bar_history_ctrl_if;

    logic [3:0] level;
    logic       level_valid;
    logic       level_ready;

    modport master (output level, output level_valid, input level_ready);
    modport slave  (input level, input level_valid, output level_ready);

endinterface

// File: rtl/bar_ring_buf.sv
// History storage: one synchronous write port, one asynchronous read port.
module bar_ring_buf #(
    parameter int unsigned DEPTH = 30,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = (rd_addr < AW'(DEPTH)) ? mem[rd_addr] : '0;

endmodule

// File: rtl/bar_history_ctrl.sv
// Scrolling bar-graph history: sample capture, vblank-synchronous commit FSM,
// and a two-stage pixel pipeline producing bar hit / colour zone / bar index.
module bar_history_ctrl
    import bar_pkg::*;
#(
    parameter int unsigned NUM_BARS          = DEF_NUM_BARS,
    parameter int unsigned BAR_W             = DEF_BAR_W,
    parameter int unsigned HEIGHT_SCALE      = DEF_HEIGHT_SCALE,
    parameter int unsigned FRAMES_PER_UPDATE = DEF_FRAMES_PER_UPDATE,
    parameter int unsigned VACTIVE           = DEF_VACTIVE
) (
    input  logic               vgaclk,
    input  logic               rst_n,
    input  logic               vblank_start,
    bar_history_ctrl_if.slave  smp,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    output logic               bar_hit,
    output logic [1:0]         zone,
    output logic [4:0]         bar_idx,
    output logic               scroll_pulse,
    output logic               underrun
);

    localparam int unsigned FCW = (FRAMES_PER_UPDATE > 1) ? $clog2(FRAMES_PER_UPDATE) : 1;

    state_t         state, state_nxt;
    logic [FCW-1:0] frame_cnt;
    logic [4:0]     wr_ptr;
    logic [3:0]     sample;
    logic           full;
    logic           ready_en;
    logic           frame_wrap;
    logic           commit;

    assign frame_wrap      = vblank_start && (frame_cnt == FCW'(FRAMES_PER_UPDATE - 1));
    assign smp.level_ready = ready_en && !full && (state == IDLE);

    always_ff @(posedge vgaclk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        commit       = 1'b0;
        scroll_pulse = 1'b0;
        underrun     = 1'b0;
        unique case (state)
            IDLE:   if (frame_wrap) state_nxt = COMMIT;
            COMMIT: begin
                commit       = 1'b1;
                scroll_pulse = 1'b1;
                underrun     = !full;
                state_nxt    = IDLE;
            end
        endcase
    end

    // ready_en keeps level_ready low until the first edge after reset release.
    always_ff @(posedge vgaclk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            wr_ptr    <= '0;
            sample    <= '0;
            full      <= 1'b0;
            ready_en  <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (vblank_start) frame_cnt <= frame_wrap ? '0 : frame_cnt + 1'b1;
            if (commit) begin
                full   <= 1'b0;
                wr_ptr <= (wr_ptr == 5'(NUM_BARS - 1)) ? '0 : wr_ptr + 5'd1;
            end else if (smp.level_valid && smp.level_ready) begin
                sample <= smp.level;
                full   <= 1'b1;
            end
        end
    end

    logic [4:0] rd_addr;
    logic [3:0] rd_data;

    bar_ring_buf #(.DEPTH(NUM_BARS), .AW(5), .DW(4)) u_ring (
        .clk     (vgaclk),
        .rst_n   (rst_n),
        .wr_en   (commit),
        .wr_addr (wr_ptr),
        .wr_data (full ? sample : 4'd0),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    logic       in_range;
    logic       s1_valid;
    logic [4:0] s1_idx;
    logic [9:0] s1_y;

    assign in_range = (x < 10'(NUM_BARS * BAR_W)) && (y < 10'(VACTIVE));

    always_ff @(posedge vgaclk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_idx   <= IDX_NONE;
            s1_y     <= '0;
        end else begin
            s1_valid <= in_range;
            s1_idx   <= in_range ? 5'(x / 10'(BAR_W)) : IDX_NONE;
            s1_y     <= y;
        end
    end

    // Bar k shows the entry k slots past the oldest one (wr_ptr).
    logic [5:0] rd_sum;
    logic [8:0] h_px;
    logic [9:0] top_y;
    logic       hit_c;
    logic [1:0] zone_c;

    assign rd_sum  = {1'b0, wr_ptr} + {1'b0, s1_idx};
    assign rd_addr = (rd_sum >= 6'(NUM_BARS)) ? 5'(rd_sum - 6'(NUM_BARS)) : rd_sum[4:0];
    assign h_px    = 9'(rd_data) * 9'(HEIGHT_SCALE);
    assign top_y   = 10'(VACTIVE) - {1'b0, h_px};
    assign hit_c   = s1_valid && (rd_data != 4'd0) && (s1_y >= top_y);

    always_comb begin
        zone_c = 2'd0;
        if (hit_c) begin
            if (s1_y > 10'(VACTIVE - ZONE0_OFS))       zone_c = 2'd0;
            else if (s1_y >= 10'(VACTIVE - ZONE1_OFS)) zone_c = 2'd1;
            else                                        zone_c = 2'd2;
        end
    end

    always_ff @(posedge vgaclk or negedge rst_n) begin
        if (!rst_n) begin
            bar_hit <= 1'b0;
            zone    <= 2'd0;
            bar_idx <= IDX_NONE;
        end else begin
            bar_hit <= hit_c;
            zone    <= zone_c;
            bar_idx <= s1_valid ? s1_idx : IDX_NONE;
        end
    end

endmodule

// File: tb/tb_bar_history_ctrl.sv
// Scoreboard bench for bar_history_ctrl: directed pixel probes and scroll events.
module tb_bar_history_ctrl;

    logic       vgaclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vblank_start = 1'b0;
    logic [9:0] x = '0;
    logic [9:0] y = '0;
    logic       bar_hit;
    logic [1:0] zone;
    logic [4:0] bar_idx;
    logic       scroll_pulse;
    logic       underrun;

    bar_history_ctrl_if smp();

    bar_history_ctrl #(
        .NUM_BARS(30), .BAR_W(21), .HEIGHT_SCALE(25),
        .FRAMES_PER_UPDATE(4), .VACTIVE(480)
    ) dut (
        .vgaclk       (vgaclk),
        .rst_n        (rst_n),
        .vblank_start (vblank_start),
        .smp          (smp),
        .x            (x),
        .y            (y),
        .bar_hit      (bar_hit),
        .zone         (zone),
        .bar_idx      (bar_idx),
        .scroll_pulse (scroll_pulse),
        .underrun     (underrun)
    );

    always #5 vgaclk = ~vgaclk;

    typedef struct {
        int unsigned due;
        logic        hit;
        logic [1:0]  zone;
        logic [4:0]  idx;
    } pix_t;

    typedef struct {
        int unsigned due;
        logic        und;
    } scr_t;

    pix_t pix_q[$];
    scr_t scr_q[$];
    pix_t pe;
    scr_t se;

    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned passed = 0;
    int unsigned fc = 0;
    logic        mfull = 1'b0;

    task automatic chk(input string name, input bit ok, input string info);
        checks++;
        if (ok) passed++;
        else    $display("FAIL %s: %s", name, info);
    endtask

    // Monitor: samples 2 time units after each rising edge.
    always begin
        @(posedge vgaclk);
        cyc++;
        #2;
        while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
            pe = pix_q.pop_front();
            if (pe.due < cyc)
                chk("pixel_timing", 1'b0, $sformatf("entry due %0d popped at %0d", pe.due, cyc));
            else
                chk("pixel", (bar_hit === pe.hit) && (zone === pe.zone) && (bar_idx === pe.idx),
                    $sformatf("cyc %0d got hit=%0b zone=%0d idx=%0d, want hit=%0b zone=%0d idx=%0d",
                              cyc, bar_hit, zone, bar_idx, pe.hit, pe.zone, pe.idx));
        end
        if (scroll_pulse || underrun) begin
            if (scr_q.size() == 0) begin
                chk("scroll_unexpected", 1'b0,
                    $sformatf("cyc %0d scroll=%0b underrun=%0b with nothing expected", cyc, scroll_pulse, underrun));
            end else begin
                se = scr_q.pop_front();
                chk("scroll", (cyc == se.due) && (scroll_pulse === 1'b1) && (underrun === se.und),
                    $sformatf("cyc %0d scroll=%0b underrun=%0b, want cyc %0d scroll=1 underrun=%0b",
                              cyc, scroll_pulse, underrun, se.due, se.und));
            end
        end else if (scr_q.size() > 0 && scr_q[0].due <= cyc) begin
            se = scr_q.pop_front();
            chk("scroll_missing", 1'b0, $sformatf("no scroll at cyc %0d, expected at %0d", cyc, se.due));
        end
    end

    task automatic probe(input int px, input int py, input bit h, input int z, input int idx);
        pix_t p;
        @(negedge vgaclk);
        x = 10'(px);
        y = 10'(py);
        p.due  = cyc + 2;
        p.hit  = h;
        p.zone = 2'(z);
        p.idx  = 5'(idx);
        pix_q.push_back(p);
    endtask

    task automatic account();
        scr_t s;
        fc++;
        if (fc == 4) begin
            fc    = 0;
            s.due = cyc + 1;
            s.und = !mfull;
            scr_q.push_back(s);
            mfull = 1'b0;
        end
    endtask

    task automatic pulse_vb();
        @(negedge vgaclk);
        vblank_start = 1'b1;
        account();
        @(negedge vgaclk);
        vblank_start = 1'b0;
    endtask

    task automatic offer(input logic [3:0] v);
        int n;
        @(negedge vgaclk);
        smp.level       = v;
        smp.level_valid = 1'b1;
        n = 0;
        while (!smp.level_ready && n < 20) begin
            @(negedge vgaclk);
            n++;
        end
        if (!smp.level_ready)
            chk("offer_timeout", 1'b0, $sformatf("level_ready=0 after %0d cycles, want 1", n));
        @(negedge vgaclk);
        smp.level_valid = 1'b0;
        mfull = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, want $finish before it");
        $fatal(1, "watchdog");
    end

    initial begin
        smp.level       = '0;
        smp.level_valid = 1'b0;
        repeat (3) @(negedge vgaclk);
        chk("reset_bar_idx", bar_idx === 5'd31, $sformatf("got %0d want 31", bar_idx));
        chk("reset_outputs", {bar_hit, zone, scroll_pulse, underrun} === 5'b0,
            $sformatf("got hit=%0b zone=%0d scroll=%0b und=%0b want all 0", bar_hit, zone, scroll_pulse, underrun));
        chk("reset_ready", smp.level_ready === 1'b0, $sformatf("got %0b want 0", smp.level_ready));
        rst_n = 1'b1;
        @(negedge vgaclk);
        chk("ready_after_reset", smp.level_ready === 1'b1, $sformatf("got %0b want 1", smp.level_ready));

        // Single sample of 7, committed on the 4th vblank.
        offer(4'd7);
        repeat (4) pulse_vb();
        probe(625, 305, 1, 1, 29);
        probe(625, 304, 0, 0, 29);
        probe(604, 305, 0, 0, 28);
        probe(629, 403, 1, 1, 29);
        probe(629, 404, 1, 0, 29);
        probe(630, 400, 0, 0, 31);
        probe(100, 480, 0, 0, 31);
        probe(20, 479, 0, 0, 0);
        probe(21, 479, 0, 0, 1);

        // Scroll without a fresh sample.
        repeat (4) pulse_vb();
        probe(625, 479, 0, 0, 29);
        probe(625, 0, 0, 0, 29);
        probe(604, 305, 1, 1, 28);
        probe(604, 304, 0, 0, 28);

        // level_valid presented during the COMMIT cycle.
        offer(4'd12);
        repeat (3) pulse_vb();
        @(negedge vgaclk);
        vblank_start = 1'b1;
        account();
        @(negedge vgaclk);
        vblank_start    = 1'b0;
        smp.level       = 4'd5;
        smp.level_valid = 1'b1;
        chk("ready_in_commit", smp.level_ready === 1'b0, $sformatf("got %0b want 0", smp.level_ready));
        @(negedge vgaclk);
        chk("ready_after_commit", smp.level_ready === 1'b1, $sformatf("got %0b want 1", smp.level_ready));
        @(negedge vgaclk);
        smp.level_valid = 1'b0;
        mfull = 1'b1;
        repeat (4) pulse_vb();
        probe(625, 355, 1, 1, 29);
        probe(625, 354, 0, 0, 29);
        probe(600, 180, 1, 2, 28);
        probe(600, 179, 0, 0, 28);
        probe(567, 479, 0, 0, 27);
        probe(546, 404, 1, 0, 26);

        // Reset asserted while the FSM is in COMMIT: that scroll is aborted.
        offer(4'd9);
        repeat (3) pulse_vb();
        @(negedge vgaclk);
        vblank_start = 1'b1;
        account();
        @(posedge vgaclk);
        #1;
        rst_n = 1'b0;
        void'(scr_q.pop_back());
        vblank_start = 1'b0;
        fc    = 0;
        mfull = 1'b0;
        #1;
        chk("reset_in_commit", (bar_idx === 5'd31) && (scroll_pulse === 1'b0),
            $sformatf("got idx=%0d scroll=%0b want idx=31 scroll=0", bar_idx, scroll_pulse));
        repeat (2) @(negedge vgaclk);
        rst_n = 1'b1;
        @(negedge vgaclk);
        probe(625, 479, 0, 0, 29);
        probe(600, 479, 0, 0, 28);
        probe(546, 479, 0, 0, 26);

        // 31 scrolls with levels i mod 16: wr_ptr wraps to 1.
        for (int i = 1; i <= 31; i++) begin
            offer(4'(i % 16));
            repeat (4) pulse_vb();
        end
        probe(0, 430, 1, 0, 0);
        probe(0, 429, 0, 0, 0);
        probe(21, 405, 1, 0, 1);
        probe(21, 404, 0, 0, 1);
        probe(294, 479, 0, 0, 14);
        probe(600, 130, 1, 2, 28);
        probe(600, 129, 0, 0, 28);
        probe(625, 105, 1, 2, 29);
        probe(625, 104, 0, 0, 29);

        repeat (6) @(negedge vgaclk);
        chk("pixel_queue_drained", pix_q.size() == 0, $sformatf("got %0d pending want 0", pix_q.size()));
        chk("scroll_queue_drained", scr_q.size() == 0, $sformatf("got %0d pending want 0", scr_q.size()));
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
